// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and helper functions.
// Used by the pool-2 stage (maxpool_relu_2 / pool2_lane).
package cnn_pkg;

    localparam int DATA_BIT     = 12;
    localparam int CONV2_WIDTH  = 8;
    localparam int CONV2_HEIGHT = 8;
    localparam int POOL2_WIDTH  = CONV2_WIDTH / 2;
    localparam int POOL2_HEIGHT = CONV2_HEIGHT / 2;

    function automatic logic [DATA_BIT-1:0] smax(
        input logic [DATA_BIT-1:0] a,
        input logic [DATA_BIT-1:0] b
    );
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [DATA_BIT-1:0] relu(
        input logic [DATA_BIT-1:0] a
    );
        return a[DATA_BIT-1] ? '0 : a;
    endfunction

endpackage

// File: rtl/pool2_lane.sv
// One channel of the 2x2 max-pool: pair hold, half-width line buffer, output reg.
// Build option MAXPOOL2_RELU_EN clamps negative pooled results to zero.
module pool2_lane
    import cnn_pkg::*;
#(
    parameter int CONV_WIDTH = CONV2_WIDTH,
    parameter int IDX_W      = $clog2(CONV_WIDTH) - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                col_odd,
    input  logic                row_odd,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_BIT-1:0] x,
    output logic [DATA_BIT-1:0] max_value
);

    logic [DATA_BIT-1:0] hold;
    logic [DATA_BIT-1:0] lbuf [CONV_WIDTH/2];
    logic [DATA_BIT-1:0] pair_max;
    logic [DATA_BIT-1:0] win_max;
    logic [DATA_BIT-1:0] pooled;

    assign pair_max = smax(hold, x);
    assign win_max  = smax(pair_max, lbuf[idx]);

`ifdef MAXPOOL2_RELU_EN
    assign pooled = relu(win_max);
`else
    assign pooled = win_max;
`endif

    // even col latches left pixel; odd col stores top pair or emits the window
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            max_value <= '0;
            for (int i = 0; i < CONV_WIDTH/2; i++) begin
                lbuf[i] <= '0;
            end
        end else if (valid_in) begin
            if (!col_odd) begin
                hold <= x;
            end else if (!row_odd) begin
                lbuf[idx] <= pair_max;
            end else begin
                max_value <= pooled;
            end
        end
    end

endmodule

// File: rtl/maxpool_relu_2.sv
// Pool-2 stage: ReLU + 2x2/2 max-pool over three lock-step conv-2 channels.
// Build option MAXPOOL2_RELU_EN selects ReLU output; otherwise raw signed max.
module maxpool_relu_2
    import cnn_pkg::*;
#(
    parameter int CONV_WIDTH  = CONV2_WIDTH,
    parameter int CONV_HEIGHT = CONV2_HEIGHT,
    parameter int DATA_BIT    = cnn_pkg::DATA_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [DATA_BIT-1:0] conv2_out_1,
    input  logic [DATA_BIT-1:0] conv2_out_2,
    input  logic [DATA_BIT-1:0] conv2_out_3,
    output logic [DATA_BIT-1:0] max_value_1,
    output logic [DATA_BIT-1:0] max_value_2,
    output logic [DATA_BIT-1:0] max_value_3,
    output logic                valid_out
);

    localparam int COL_W = $clog2(CONV_WIDTH);
    localparam int ROW_W = $clog2(CONV_HEIGHT);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;
    logic             win_done;

    assign col_last = (col == COL_W'(CONV_WIDTH - 1));
    assign row_last = (row == ROW_W'(CONV_HEIGHT - 1));
    assign win_done = valid_in & col[0] & row[0];

    // raster position; frozen on bubbles, wraps at end of frame
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // one-cycle strobe after the bottom-right pixel of each window
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= win_done;
        end
    end

    pool2_lane #(.CONV_WIDTH(CONV_WIDTH)) u_lane_1 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .col_odd   (col[0]),
        .row_odd   (row[0]),
        .idx       (col[COL_W-1:1]),
        .x         (conv2_out_1),
        .max_value (max_value_1)
    );

    pool2_lane #(.CONV_WIDTH(CONV_WIDTH)) u_lane_2 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .col_odd   (col[0]),
        .row_odd   (row[0]),
        .idx       (col[COL_W-1:1]),
        .x         (conv2_out_2),
        .max_value (max_value_2)
    );

    pool2_lane #(.CONV_WIDTH(CONV_WIDTH)) u_lane_3 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .col_odd   (col[0]),
        .row_odd   (row[0]),
        .idx       (col[COL_W-1:1]),
        .x         (conv2_out_3),
        .max_value (max_value_3)
    );

endmodule

// File: tb/tb_maxpool_relu_2.sv
// Directed/table-driven bench for maxpool_relu_2 (both MAXPOOL2_RELU_EN builds).
module tb_maxpool_relu_2;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NP = W * H;
    localparam int NW = (W / 2) * (H / 2);

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [11:0] conv2_out_1, conv2_out_2, conv2_out_3;
    logic [11:0] max_value_1, max_value_2, max_value_3;
    logic        valid_out;

    always #5 clk = ~clk;

    maxpool_relu_2 dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .conv2_out_1 (conv2_out_1),
        .conv2_out_2 (conv2_out_2),
        .conv2_out_3 (conv2_out_3),
        .max_value_1 (max_value_1),
        .max_value_2 (max_value_2),
        .max_value_3 (max_value_3),
        .valid_out   (valid_out)
    );

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int raw;
    } win_t;

    win_t        tbl [NW];
    logic [11:0] img1 [NP];
    logic [11:0] img2 [NP];
    logic [11:0] img3 [NP];
    logic [11:0] e1 [NW];
    logic [11:0] e2 [NW];
    logic [11:0] e3 [NW];

    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   brow    = 0;
    int   bcol    = 0;
    int   strobes = 0;
    logic prev_vo = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] fix(input int v);
        int t;
        t = v;
`ifdef MAXPOOL2_RELU_EN
        if (t < 0) t = 0;
`endif
        return t[11:0];
    endfunction

    function automatic int s(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    // reference: max over the four pixels of each window, computed from frames
    task automatic build_model();
        for (int w = 0; w < NW; w++) begin
            int pr, pc, m1, m2, m3, p;
            pr = (w / (W/2)) * 2;
            pc = (w % (W/2)) * 2;
            m1 = -100000; m2 = -100000; m3 = -100000;
            for (int k = 0; k < 4; k++) begin
                p = (pr + k/2) * W + pc + k%2;
                if (s(img1[p]) > m1) m1 = s(img1[p]);
                if (s(img2[p]) > m2) m2 = s(img2[p]);
                if (s(img3[p]) > m3) m3 = s(img3[p]);
            end
            e1[w] = fix(m1);
            e2[w] = fix(m2);
            e3[w] = fix(m3);
        end
    endtask

    task automatic cycle(input logic v, input logic r, input logic [11:0] a,
                         input logic [11:0] b, input logic [11:0] c);
        logic exp_vo;
        int   widx;
        valid_in    = v;
        rst         = r;
        conv2_out_1 = a;
        conv2_out_2 = b;
        conv2_out_3 = c;
        @(posedge clk);
        #1;
        exp_vo = !r && v && (brow % 2 == 1) && (bcol % 2 == 1);
        chk("valid_out", 32'(valid_out), 32'(exp_vo));
        chk("no_double", 32'(prev_vo & valid_out), 32'd0);
        prev_vo = valid_out;
        if (exp_vo) begin
            widx = (brow / 2) * (W/2) + bcol / 2;
            strobes++;
            chk($sformatf("ch1_w%0d", widx), 32'(max_value_1), 32'(e1[widx]));
            chk($sformatf("ch2_w%0d", widx), 32'(max_value_2), 32'(e2[widx]));
            chk($sformatf("ch3_w%0d", widx), 32'(max_value_3), 32'(e3[widx]));
        end
        if (r) begin
            brow = 0;
            bcol = 0;
        end else if (v) begin
            if (bcol == W - 1) begin
                bcol = 0;
                brow = (brow == H - 1) ? 0 : brow + 1;
            end else begin
                bcol++;
            end
        end
    endtask

    task automatic send_frame(input int bubble_pct);
        for (int p = 0; p < NP; p++) begin
            int nb;
            nb = 0;
            while (bubble_pct > 0 && nb < 8 &&
                   $urandom_range(99) < 32'(bubble_pct)) begin
                cycle(1'b0, 1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
                nb++;
            end
            cycle(1'b1, 1'b0, img1[p], img2[p], img3[p]);
        end
    endtask

    task automatic randomize_frame();
        for (int p = 0; p < NP; p++) begin
            img1[p] = 12'($urandom);
            img2[p] = 12'($urandom);
            img3[p] = 12'($urandom);
        end
    endtask

    initial begin
        int st0;

        tbl[0]  = '{-100, 7, -3, 2, 7};
        tbl[1]  = '{-1, -2, -3, -4, -1};
        tbl[2]  = '{0, 0, 0, 0, 0};
        tbl[3]  = '{2047, -2048, 0, 1, 2047};
        tbl[4]  = '{-2048, -2048, -2048, -2048, -2048};
        tbl[5]  = '{5, 5, 5, 5, 5};
        tbl[6]  = '{1, 2, 3, 4, 4};
        tbl[7]  = '{4, 3, 2, 1, 4};
        tbl[8]  = '{-7, 100, -9, -9, 100};
        tbl[9]  = '{-9, -9, 100, -7, 100};
        tbl[10] = '{-9, -9, -7, 100, 100};
        tbl[11] = '{-1, 0, -1, -1, 0};
        tbl[12] = '{-300, -200, -250, -201, -200};
        tbl[13] = '{10, -10, 20, -20, 20};
        tbl[14] = '{-2048, 2047, -1, 1, 2047};
        tbl[15] = '{-5, -6, -7, -8, -5};

        // reset state
        cycle(1'b0, 1'b1, 12'h0, 12'h0, 12'h0);
        cycle(1'b0, 1'b1, 12'h0, 12'h0, 12'h0);
        chk("rst_mv1", 32'(max_value_1), 32'd0);
        chk("rst_mv2", 32'(max_value_2), 32'd0);
        chk("rst_mv3", 32'(max_value_3), 32'd0);

        // frame 1: ramp, constant -5, table windows
        for (int p = 0; p < NP; p++) begin
            int r, c, w, k, v;
            r = p / W;
            c = p % W;
            w = (r / 2) * (W/2) + c / 2;
            k = (r % 2) * 2 + c % 2;
            v = (k == 0) ? tbl[w].a : (k == 1) ? tbl[w].b :
                (k == 2) ? tbl[w].c : tbl[w].d;
            img1[p] = 12'(p);
            img2[p] = 12'hFFB;
            img3[p] = v[11:0];
        end
        for (int w = 0; w < NW; w++) begin
            e1[w] = 12'((2 * (w / 4) + 1) * 8 + 2 * (w % 4) + 1);
            e2[w] = fix(-5);
            e3[w] = fix(tbl[w].raw);
        end
        st0 = strobes;
        send_frame(0);
        chk("frame1_strobes", 32'(strobes - st0), 32'd16);
        cycle(1'b0, 1'b0, 12'h123, 12'h456, 12'h789);
        chk("hold_mv1", 32'(max_value_1), 32'd63);
        chk("hold_mv3", 32'(max_value_3), 32'(fix(-5)));

        // two back-to-back frames with ~50% bubbles
        st0 = strobes;
        randomize_frame();
        build_model();
        send_frame(50);
        randomize_frame();
        build_model();
        send_frame(50);
        chk("bubble_strobes", 32'(strobes - st0), 32'd32);

        // reset mid-frame at row 3, col 5 (sample on that cycle is dropped)
        randomize_frame();
        build_model();
        for (int p = 0; p < 3 * W + 5; p++) begin
            cycle(1'b1, 1'b0, img1[p], img2[p], img3[p]);
        end
        cycle(1'b1, 1'b1, img1[29], img2[29], img3[29]);
        chk("midrst_mv1", 32'(max_value_1), 32'd0);
        chk("midrst_mv2", 32'(max_value_2), 32'd0);
        chk("midrst_mv3", 32'(max_value_3), 32'd0);
        cycle(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
        randomize_frame();
        build_model();
        st0 = strobes;
        send_frame(0);
        chk("postrst_strobes", 32'(strobes - st0), 32'd16);
        cycle(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
